// File: rtl/obuf_accum_sched.sv
// Output-buffer accumulation scheduler: sequences reduction passes and tiles,
// selecting bias vs. partial-sum seeding. Optional status counter via OBUF_ACCUM_SCHED_STATUS_EN.
module obuf_accum_sched #(
  parameter int unsigned ITER_W = 16,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_v,
  input  logic [ITER_W-1:0] cfg_pass_num,
  input  logic [ITER_W-1:0] cfg_tile_num,
  input  logic              start,
  input  logic              abort,
  input  logic              compute_done,
  output logic              obuf_bias_sel_out,
  output logic              last_pass,
  output logic              tile_done,
  output logic              busy,
  output logic              done
`ifdef OBUF_ACCUM_SCHED_STATUS_EN
  ,
  output logic [STAT_W-1:0] stat_pass_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ITER_W-1:0] pass_num;
  logic [ITER_W-1:0] tile_num;
  logic [ITER_W-1:0] pass_cnt;
  logic [ITER_W-1:0] tile_cnt;
  logic              sel_reg;
  logic              last_reg;

  logic cd_acc;
  logic pass_last;
  logic tile_last;
  logic start_acc;

  // Abort wins over compute_done; start is only honoured when idle.
  assign cd_acc    = compute_done && (state == RUN) && !abort;
  assign pass_last = (pass_cnt == pass_num);
  assign tile_last = (tile_cnt == tile_num);
  assign start_acc = start && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort) state_nxt = IDLE;
        else if (cd_acc && pass_last && tile_last) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Configuration capture and pass/tile counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_num <= '0;
      tile_num <= '0;
      pass_cnt <= '0;
      tile_cnt <= '0;
    end else begin
      if ((state == IDLE) && cfg_v) begin
        pass_num <= cfg_pass_num;
        tile_num <= cfg_tile_num;
      end
      if (start_acc || ((state == RUN) && abort)) begin
        pass_cnt <= '0;
        tile_cnt <= '0;
      end else if (cd_acc) begin
        if (pass_last) begin
          pass_cnt <= '0;
          tile_cnt <= tile_last ? '0 : tile_cnt + ITER_W'(1);
        end else begin
          pass_cnt <= pass_cnt + ITER_W'(1);
        end
      end
    end
  end

  // Two-stage pipeline so select and last-pass flags land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg           <= 1'b0;
      last_reg          <= 1'b0;
      obuf_bias_sel_out <= 1'b0;
      last_pass         <= 1'b0;
      tile_done         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      sel_reg           <= (pass_cnt != '0);
      last_reg          <= pass_last && (state == RUN);
      obuf_bias_sel_out <= sel_reg;
      last_pass         <= last_reg;
      tile_done         <= cd_acc && pass_last;
      busy              <= (state_nxt == RUN);
      done              <= (state_nxt == FIN);
    end
  end

`ifdef OBUF_ACCUM_SCHED_STATUS_EN
  // Accepted-pass counter, saturating; retains its value once the job ends.
  always_ff @(posedge clk) begin
    if (reset || start_acc) stat_pass_cnt <= '0;
    else if (cd_acc && (stat_pass_cnt != '1)) stat_pass_cnt <= stat_pass_cnt + STAT_W'(1);
  end
`endif

endmodule

// File: doc/obuf_accum_sched.md
OBUF_ACCUM_SCHED -- requirements
Module: obuf_accum_sched

Interface
REQ-001 SHALL have parameter ITER_W, default 16, width of pass/tile count fields.
REQ-002 SHALL have parameter STAT_W, default 32, width of status pass counter.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_v  input  1  config strobe; captures cfg_pass_num/cfg_tile_num.
REQ-006 SHALL have port cfg_pass_num  input  ITER_W  reduction passes per output tile minus one.
REQ-007 SHALL have port cfg_tile_num  input  ITER_W  output tiles per job minus one.
REQ-008 SHALL have port start  input  1  job start pulse.
REQ-009 SHALL have port abort  input  1  job cancel pulse.
REQ-010 SHALL have port compute_done  input  1  one-cycle pulse marking end of one compute pass.
REQ-011 SHALL have port obuf_bias_sel_out  output  1  0 = seed accumulation from bias, 1 = from obuf partial sum.
REQ-012 SHALL have port last_pass  output  1  current pass is final reduction pass of tile.
REQ-013 SHALL have port tile_done  output  1  one-cycle pulse, tile reduction complete.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse, job complete.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FIN; IDLE->RUN on start; RUN->FIN on compute_done of last pass of last tile; FIN->IDLE unconditionally next cycle; RUN->IDLE on abort.
REQ-017 SHALL latch cfg_pass_num/cfg_tile_num into pass_num/tile_num on cfg_v only in IDLE; cfg_v in RUN/FIN ignored.
REQ-018 SHALL, on cfg_v and start in same IDLE cycle, run the job with the newly captured values.
REQ-019 SHALL clear pass_cnt and tile_cnt to 0 on start in IDLE; start outside IDLE ignored.
REQ-020 SHALL, on compute_done in RUN with pass_cnt != pass_num, increment pass_cnt.
REQ-021 SHALL, on compute_done in RUN with pass_cnt == pass_num, set pass_cnt to 0, pulse tile_done next cycle, and increment tile_cnt unless tile_cnt == tile_num (then enter FIN).
REQ-022 SHALL ignore compute_done in IDLE and FIN.
REQ-023 SHALL compute sel_reg = (pass_cnt != 0) registered, then delay one more register to obuf_bias_sel_out: output reflects a pass_cnt change 2 cycles after the compute_done edge.
REQ-024 SHALL drive last_pass = (pass_cnt == pass_num) with busy, aligned with obuf_bias_sel_out (same 2-register delay).
REQ-025 SHALL, with pass_num == 0, hold obuf_bias_sel_out at 0 and last_pass at 1 for every pass.
REQ-026 SHALL pulse done for exactly one cycle, in the cycle the FSM is in FIN.
REQ-027 SHALL give abort priority over compute_done in the same cycle; abort suppresses tile_done/done and clears counters.
REQ-028 SHALL compare counters at full ITER_W width with no wrap; pass_cnt never exceeds pass_num.

Reset
REQ-029 SHALL on reset force state IDLE, pass_cnt=0, tile_cnt=0, pass_num=0, tile_num=0, both sel registers 0.
REQ-030 SHALL hold outputs after reset: obuf_bias_sel_out=0, last_pass=0, tile_done=0, busy=0, done=0.
REQ-031 SHALL, on reset mid-job, abandon job with no done pulse; reset overrides all other inputs.

Configuration
REQ-032 SHALL, with macro OBUF_ACCUM_SCHED_STATUS_EN defined, add output stat_pass_cnt [STAT_W-1:0], cleared on reset and start, incremented on each accepted compute_done, saturating at all-ones, held after done.
REQ-033 SHALL, without OBUF_ACCUM_SCHED_STATUS_EN, omit port stat_pass_cnt and its logic; all other behaviour identical.

Verification
REQ-034 SHALL test cfg_pass_num=2, cfg_tile_num=1, start, 6 compute_done -> sel sequence 0,1,1,0,1,1; tile_done after pulses 3 and 6; done once after pulse 6.
REQ-035 SHALL test cfg_pass_num=0, cfg_tile_num=3, 4 compute_done -> sel always 0, last_pass 1, 4 tile_done, done after 4th.
REQ-036 SHALL test abort coincident with 2nd compute_done of pass_num=3 job -> IDLE, no tile_done/done, sel returns 0 within 2 cycles.
REQ-037 SHALL test cfg_v with pass_num=5 during RUN of pass_num=1 job -> ignored, job ends after 2 passes per tile.
REQ-038 SHALL test reset asserted mid-job after 3 compute_done -> all outputs 0 next cycle; with STATUS_EN, stat_pass_cnt 0.
REQ-039 SHALL test compute_done in IDLE and a 2nd start in RUN -> no counter or output change.
